// File: rtl/mem_bank_sweep_arbiter.sv
// Sweeps every bank/address of the banked parameter memory once per sample tick.
// It also shares the write port with the host, stalling writes that would hit the word being read.
module mem_bank_sweep_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 18,
    parameter int NUM_BANKS    = 2,
    parameter int OUTPUT_DELAY = 1,
    parameter int BANK_WIDTH   = $clog2(NUM_BANKS),
    parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_clk_en,
    input  logic                  host_wr_req,
    input  logic [BANK_WIDTH-1:0] host_wr_bank,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    output logic                  host_wr_ack,
    output logic                  mem_wea,
    output logic [BANK_WIDTH-1:0] mem_banka,
    output logic [ADDR_WIDTH-1:0] mem_addra,
    output logic [DATA_WIDTH-1:0] mem_dia,
    output logic                  mem_reb,
    output logic [BANK_WIDTH-1:0] mem_bankb,
    output logic [ADDR_WIDTH-1:0] mem_addrb,
    input  logic [DATA_WIDTH-1:0] mem_dob,
    output logic                  rd_valid,
    output logic [BANK_WIDTH-1:0] rd_bank,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  sweep_busy,
    output logic                  overrun
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [BANK_WIDTH-1:0] BANK_LAST = BANK_WIDTH'(NUM_BANKS - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    reb_next;
    logic [BANK_WIDTH-1:0]   bank_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic                    overrun_next;
    logic                    last_pos;
    logic                    collision;
    logic                    addr_ok;

    logic [OUTPUT_DELAY-1:0] vld_pipe;
    logic [BANK_WIDTH-1:0]   bank_pipe [OUTPUT_DELAY];
    logic [ADDR_WIDTH-1:0]   addr_pipe [OUTPUT_DELAY];

    assign last_pos   = (mem_bankb == BANK_LAST) && (mem_addrb == ADDR_LAST);
    assign sweep_busy = (state == SWEEP);

    always_comb begin
        state_next   = state;
        reb_next     = 1'b0;
        bank_next    = '0;
        addr_next    = '0;
        overrun_next = 1'b0;
        case (state)
            IDLE: begin
                if (sample_clk_en) begin
                    state_next = SWEEP;
                    reb_next   = 1'b1;
                end
            end
            SWEEP: begin
                // A tick on the final position chains straight into the next sweep.
                if (last_pos) begin
                    if (sample_clk_en) begin
                        reb_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    reb_next     = 1'b1;
                    overrun_next = sample_clk_en;
                    if (mem_addrb == ADDR_LAST) begin
                        bank_next = mem_bankb + BANK_WIDTH'(1);
                    end else begin
                        bank_next = mem_bankb;
                        addr_next = mem_addrb + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_reb   <= 1'b0;
            mem_bankb <= '0;
            mem_addrb <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            mem_reb   <= reb_next;
            mem_bankb <= bank_next;
            mem_addrb <= addr_next;
            overrun   <= overrun_next;
        end
    end

    // Compare against the position that will appear on the read port next cycle.
    assign collision   = reb_next && (host_wr_bank == bank_next) && (host_wr_addr == addr_next);
    assign host_wr_ack = host_wr_req && !collision;
    assign addr_ok     = (host_wr_addr <= ADDR_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_wea   <= 1'b0;
            mem_banka <= '0;
            mem_addra <= '0;
            mem_dia   <= '0;
        end else begin
            mem_wea <= host_wr_ack && addr_ok;
            if (host_wr_ack && addr_ok) begin
                mem_banka <= host_wr_bank;
                mem_addra <= host_wr_addr;
                mem_dia   <= host_wr_data;
            end
        end
    end

    // Tags ride alongside the memory latency so they line up with mem_dob.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < OUTPUT_DELAY; i++) begin
                bank_pipe[i] <= '0;
                addr_pipe[i] <= '0;
            end
            rd_valid <= 1'b0;
            rd_bank  <= '0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else begin
            vld_pipe[0]  <= mem_reb;
            bank_pipe[0] <= mem_bankb;
            addr_pipe[0] <= mem_addrb;
            for (int i = 1; i < OUTPUT_DELAY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                bank_pipe[i] <= bank_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            rd_valid <= vld_pipe[OUTPUT_DELAY-1];
            if (vld_pipe[OUTPUT_DELAY-1]) begin
                rd_bank <= bank_pipe[OUTPUT_DELAY-1];
                rd_addr <= addr_pipe[OUTPUT_DELAY-1];
                rd_data <= mem_dob;
            end
        end
    end

endmodule
